// File: rtl/mul_sequencer.sv
// Iterative RV32M multiply controller: carry-save accumulation of BITS_PER_CYCLE
// partial products per cycle, one carry-propagate add plus sign fix-up at the end.

module carry_save_adder (
    input  logic [63:0] x,
    input  logic [63:0] y,
    input  logic [63:0] z,
    output logic [63:0] s,
    output logic [63:0] c
);
    assign s = x ^ y ^ z;
    assign c = {(x[62:0] & y[62:0]) | (x[62:0] & z[62:0]) | (y[62:0] & z[62:0]), 1'b0};
endmodule

module mul_sequencer #(
    parameter int unsigned BITS_PER_CYCLE = 4,
    parameter int unsigned TAG_W          = 4
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic             rdy_in,
    input  logic             flush_in,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       in_op,
    input  logic [31:0]      in_a,
    input  logic [31:0]      in_b,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_result,
    output logic [TAG_W-1:0] out_tag
);
    localparam int unsigned ITERS    = 32 / BITS_PER_CYCLE;
    localparam logic [5:0]  CNT_LAST = 6'(ITERS - 1);

    typedef enum logic [1:0] {IDLE, ITER, FINAL, DONE} state_t;

    state_t           state_q, state_d;
    logic [5:0]       count_q, count_d;
    logic [63:0]      sum_q, sum_d, carry_q, carry_d;
    logic [63:0]      a_sh_q, a_sh_d;
    logic [31:0]      b_sh_q, b_sh_d;
    logic             neg_q, neg_d;
    logic [1:0]       op_q, op_d;
    logic [TAG_W-1:0] tag_q, tag_d;
    logic             out_valid_d;
    logic [31:0]      out_result_d;
    logic [TAG_W-1:0] out_tag_d;

    logic             a_neg, b_neg;
    logic [31:0]      a_mag, b_mag;
    logic [63:0]      prod_raw, prod;

    assign in_ready = (state_q == IDLE);

    // Magnitudes: negating 0x80000000 in 32 bits yields 0x80000000, the correct unsigned magnitude.
    assign a_neg = ((in_op == 2'b01) || (in_op == 2'b10)) && in_a[31];
    assign b_neg = (in_op == 2'b01) && in_b[31];
    assign a_mag = a_neg ? (~in_a + 32'd1) : in_a;
    assign b_mag = b_neg ? (~in_b + 32'd1) : in_b;

    assign prod_raw = sum_q + carry_q;
    assign prod     = neg_q ? (~prod_raw + 64'd1) : prod_raw;

    // a_sh tracks |a| pre-shifted to the current bit position; b_sh exposes the next bits at [BITS_PER_CYCLE-1:0].
    logic [63:0] pp      [BITS_PER_CYCLE];
    logic [63:0] s_chain [BITS_PER_CYCLE+1];
    logic [63:0] c_chain [BITS_PER_CYCLE+1];

    assign s_chain[0] = sum_q;
    assign c_chain[0] = carry_q;

    for (genvar j = 0; j < BITS_PER_CYCLE; j++) begin : g_csa
        assign pp[j] = b_sh_q[j] ? (a_sh_q << j) : '0;
        carry_save_adder u_csa (
            .x (s_chain[j]),
            .y (c_chain[j]),
            .z (pp[j]),
            .s (s_chain[j+1]),
            .c (c_chain[j+1])
        );
    end

    always_comb begin
        state_d      = state_q;
        count_d      = count_q;
        sum_d        = sum_q;
        carry_d      = carry_q;
        a_sh_d       = a_sh_q;
        b_sh_d       = b_sh_q;
        neg_d        = neg_q;
        op_d         = op_q;
        tag_d        = tag_q;
        out_valid_d  = out_valid;
        out_result_d = out_result;
        out_tag_d    = out_tag;

        if (flush_in) begin
            state_d     = IDLE;
            out_valid_d = 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        state_d = ITER;
                        count_d = '0;
                        sum_d   = '0;
                        carry_d = '0;
                        a_sh_d  = {32'd0, a_mag};
                        b_sh_d  = b_mag;
                        neg_d   = a_neg ^ b_neg;
                        op_d    = in_op;
                        tag_d   = in_tag;
                    end
                end
                ITER: begin
                    sum_d   = s_chain[BITS_PER_CYCLE];
                    carry_d = c_chain[BITS_PER_CYCLE];
                    a_sh_d  = a_sh_q << BITS_PER_CYCLE;
                    b_sh_d  = b_sh_q >> BITS_PER_CYCLE;
                    count_d = count_q + 6'd1;
                    if (count_q == CNT_LAST) begin
                        state_d = FINAL;
                    end
                end
                FINAL: begin
                    out_result_d = (op_q == 2'b00) ? prod[31:0] : prod[63:32];
                    out_tag_d    = tag_q;
                    out_valid_d  = 1'b1;
                    state_d      = DONE;
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid_d = 1'b0;
                        state_d     = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q    <= IDLE;
            count_q    <= '0;
            sum_q      <= '0;
            carry_q    <= '0;
            a_sh_q     <= '0;
            b_sh_q     <= '0;
            neg_q      <= 1'b0;
            op_q       <= '0;
            tag_q      <= '0;
            out_valid  <= 1'b0;
            out_result <= '0;
            out_tag    <= '0;
        end else if (rdy_in) begin
            state_q    <= state_d;
            count_q    <= count_d;
            sum_q      <= sum_d;
            carry_q    <= carry_d;
            a_sh_q     <= a_sh_d;
            b_sh_q     <= b_sh_d;
            neg_q      <= neg_d;
            op_q       <= op_d;
            tag_q      <= tag_d;
            out_valid  <= out_valid_d;
            out_result <= out_result_d;
            out_tag    <= out_tag_d;
        end
    end
endmodule

// File: tb/tb_mul_sequencer.sv
// Scoreboard bench for mul_sequencer: expectations queued at accept, checked when results appear.

module tb_mul_sequencer;
    localparam int LAT = 32 / 4 + 1;

    logic        clk = 1'b0;
    logic        rst_in = 1'b1, rdy_in = 1'b1, flush_in = 1'b0;
    logic        in_valid = 1'b0, out_ready = 1'b1;
    logic        in_ready, out_valid;
    logic [1:0]  in_op = '0;
    logic [31:0] in_a = '0, in_b = '0, out_result;
    logic [3:0]  in_tag = '0, out_tag;

    typedef struct packed {
        logic [31:0] res;
        logic [3:0]  tag;
    } exp_t;

    exp_t q[$];
    exp_t e;
    int   cyc = 0;
    int   n_cmp = 0, n_err = 0;

    mul_sequencer #(.BITS_PER_CYCLE(4), .TAG_W(4)) dut (
        .clk_in(clk), .rst_in(rst_in), .rdy_in(rdy_in), .flush_in(flush_in),
        .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op), .in_a(in_a),
        .in_b(in_b), .in_tag(in_tag), .out_valid(out_valid), .out_ready(out_ready),
        .out_result(out_result), .out_tag(out_tag)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] ref_mul(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] ea, eb, p;
        ea = ((op == 2'b01) || (op == 2'b10)) ? {{32{a[31]}}, a} : {32'd0, a};
        eb = (op == 2'b01) ? {{32{b[31]}}, b} : {32'd0, b};
        p  = ea * eb;
        return (op == 2'b00) ? p[31:0] : p[63:32];
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drives a request until accepted; records the accept edge and queues the expectation.
    task automatic send(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [3:0] tag, input logic [31:0] expv, output int acc_cyc, output bit ok);
        bit acc;
        ok = 1'b0;
        acc_cyc = -1;
        in_valid = 1'b1; in_op = op; in_a = a; in_b = b; in_tag = tag;
        for (int k = 0; k < 60; k++) begin
            acc = in_ready && rdy_in && !flush_in && !rst_in;
            step();
            if (acc) begin
                ok = 1'b1;
                acc_cyc = cyc;
                break;
            end
        end
        in_valid = 1'b0;
        if (ok) q.push_back('{res: expv, tag: tag});
    endtask

    task automatic wait_valid(output int seen_cyc, output bit ok);
        ok = 1'b0;
        seen_cyc = -1;
        for (int k = 0; k < 100; k++) begin
            if (out_valid) begin
                ok = 1'b1;
                seen_cyc = cyc;
                break;
            end
            step();
        end
    endtask

    task automatic test_reset();
        rst_in = 1'b1;
        step(); step();
        n_cmp++;
        if ({in_ready, out_valid, out_result, out_tag} !== {1'b1, 1'b0, 32'd0, 4'd0}) begin
            n_err++;
            $display("FAIL reset_state: got rdy=%b vld=%b res=%h tag=%h, want 1 0 0 0",
                     in_ready, out_valid, out_result, out_tag);
        end
        rst_in = 1'b0;
        step();
    endtask

    task automatic test_basic();
        int acc, seen; bit ok, vok;
        send(2'b00, 32'd3, 32'd5, 4'd2, 32'h0000000F, acc, ok);
        wait_valid(seen, vok);
        n_cmp++;
        if (!ok || !vok || (seen - acc) !== LAT) begin
            n_err++;
            $display("FAIL basic_latency: got %0d (acc=%b valid=%b), want %0d", seen - acc, ok, vok, LAT);
        end
        e = q.pop_front();
        n_cmp++;
        if (out_result !== e.res || out_tag !== e.tag) begin
            n_err++;
            $display("FAIL basic_result: got %h/%h, want %h/%h", out_result, out_tag, e.res, e.tag);
        end
        step();
        n_cmp++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL basic_ready_after: got rdy=%b vld=%b, want 1 0", in_ready, out_valid);
        end
    endtask

    task automatic test_arith();
        logic [1:0]  ops  [5] = '{2'b11, 2'b00, 2'b01, 2'b01, 2'b10};
        logic [31:0] as   [5] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFF};
        logic [31:0] bs   [5] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'h80000000, 32'hFFFFFFFF, 32'd2};
        logic [31:0] exps [5] = '{32'hFFFFFFFE, 32'h00000001, 32'h40000000, 32'h00000000, 32'hFFFFFFFF};
        int acc, seen; bit ok, vok;
        logic [1:0] op; logic [31:0] a, b, x;
        for (int i = 0; i < 17; i++) begin
            if (i < 5) begin
                op = ops[i]; a = as[i]; b = bs[i]; x = exps[i];
            end else begin
                op = 2'($urandom_range(0, 3)); a = $urandom(); b = $urandom();
                if (i == 5) a = 32'h80000000;
                if (i == 6) b = 32'h80000000;
                x = ref_mul(op, a, b);
            end
            send(op, a, b, 4'(i), x, acc, ok);
            wait_valid(seen, vok);
            e = q.pop_front();
            n_cmp++;
            if (!ok || !vok || out_result !== e.res || out_tag !== e.tag) begin
                n_err++;
                $display("FAIL arith_%0d op=%0d a=%h b=%h: got %h/%h, want %h/%h",
                         i, op, a, b, out_result, out_tag, e.res, e.tag);
            end
            step();
        end
    endtask

    task automatic test_backpressure();
        int acc, seen, hs; bit ok, vok;
        logic [31:0] held_r; logic [3:0] held_t;
        out_ready = 1'b0;
        send(2'b11, 32'hDEADBEEF, 32'h12345678, 4'd9, ref_mul(2'b11, 32'hDEADBEEF, 32'h12345678), acc, ok);
        wait_valid(seen, vok);
        e = q.pop_front();
        n_cmp++;
        if (!vok || out_result !== e.res || out_tag !== e.tag) begin
            n_err++;
            $display("FAIL bp_result: got %h/%h, want %h/%h", out_result, out_tag, e.res, e.tag);
        end
        held_r = e.res; held_t = e.tag;
        in_valid = 1'b1; in_op = 2'b00; in_a = 32'd11; in_b = 32'd13; in_tag = 4'd4;
        for (int k = 0; k < 5; k++) begin
            step();
            n_cmp++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_result !== held_r || out_tag !== held_t) begin
                n_err++;
                $display("FAIL bp_hold_%0d: got vld=%b rdy=%b %h/%h, want 1 0 %h/%h",
                         k, out_valid, in_ready, out_result, out_tag, held_r, held_t);
            end
        end
        out_ready = 1'b1;
        hs = cyc + 1;
        send(2'b00, 32'd11, 32'd13, 4'd4, 32'd143, acc, ok);
        n_cmp++;
        if (!ok || acc !== hs + 1) begin
            n_err++;
            $display("FAIL bp_next_accept: got edge %0d, want %0d", acc, hs + 1);
        end
        wait_valid(seen, vok);
        e = q.pop_front();
        n_cmp++;
        if (!vok || out_result !== e.res || out_tag !== e.tag) begin
            n_err++;
            $display("FAIL bp_second: got %h/%h, want %h/%h", out_result, out_tag, e.res, e.tag);
        end
        step();
    endtask

    task automatic test_flush();
        int acc, seen; bit ok, vok, leaked;
        send(2'b00, 32'h1234, 32'h5678, 4'd5, 32'h1234 * 32'h5678, acc, ok);
        void'(q.pop_back());
        step(); step(); step();
        flush_in = 1'b1;
        step();
        flush_in = 1'b0;
        n_cmp++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL flush_iter: got rdy=%b vld=%b, want 1 0", in_ready, out_valid);
        end
        leaked = 1'b0;
        for (int k = 0; k < 12; k++) begin
            if (out_valid) leaked = 1'b1;
            step();
        end
        n_cmp++;
        if (leaked !== 1'b0) begin
            n_err++;
            $display("FAIL flush_no_output: got out_valid seen=%b, want 0", leaked);
        end
        send(2'b00, 32'd7, 32'd6, 4'd6, 32'd42, acc, ok);
        wait_valid(seen, vok);
        e = q.pop_front();
        n_cmp++;
        if (!vok || (seen - acc) !== LAT || out_result !== e.res || out_tag !== e.tag) begin
            n_err++;
            $display("FAIL flush_next: got lat=%0d %h/%h, want %0d %h/%h",
                     seen - acc, out_result, out_tag, LAT, e.res, e.tag);
        end
        step();
        out_ready = 1'b0;
        send(2'b01, 32'hFFFFFFF0, 32'd3, 4'd7, ref_mul(2'b01, 32'hFFFFFFF0, 32'd3), acc, ok);
        void'(q.pop_back());
        wait_valid(seen, vok);
        flush_in = 1'b1;
        step();
        flush_in = 1'b0;
        out_ready = 1'b1;
        n_cmp++;
        if (!vok || out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL flush_done: got vld=%b rdy=%b, want 0 1", out_valid, in_ready);
        end
    endtask

    task automatic test_stall();
        int acc, seen; bit ok, vok;
        send(2'b10, 32'h87654321, 32'hCAFEF00D, 4'd8, ref_mul(2'b10, 32'h87654321, 32'hCAFEF00D), acc, ok);
        step(); step();
        rdy_in = 1'b0;
        step(); step(); step();
        rdy_in = 1'b1;
        wait_valid(seen, vok);
        e = q.pop_front();
        n_cmp++;
        if (!vok || (seen - acc) !== LAT + 3 || out_result !== e.res || out_tag !== e.tag) begin
            n_err++;
            $display("FAIL stall: got lat=%0d %h/%h, want %0d %h/%h",
                     seen - acc, out_result, out_tag, LAT + 3, e.res, e.tag);
        end
        step();
    endtask

    task automatic test_back_to_back();
        int acc1, acc2, seen; bit ok, vok;
        send(2'b00, 32'd100, 32'd200, 4'd10, 32'd20000, acc1, ok);
        wait_valid(seen, vok);
        e = q.pop_front();
        n_cmp++;
        if (!vok || out_result !== e.res || out_tag !== e.tag) begin
            n_err++;
            $display("FAIL b2b_first: got %h/%h, want %h/%h", out_result, out_tag, e.res, e.tag);
        end
        send(2'b11, 32'h00010000, 32'h00010000, 4'd11, 32'd1, acc2, ok);
        n_cmp++;
        if (!ok || (acc2 - acc1) !== LAT + 2) begin
            n_err++;
            $display("FAIL b2b_spacing: got %0d, want %0d", acc2 - acc1, LAT + 2);
        end
        wait_valid(seen, vok);
        e = q.pop_front();
        n_cmp++;
        if (!vok || out_result !== e.res || out_tag !== e.tag) begin
            n_err++;
            $display("FAIL b2b_second: got %h/%h, want %h/%h", out_result, out_tag, e.res, e.tag);
        end
        step();
    endtask

    task automatic test_reset_midop();
        int acc; bit ok;
        send(2'b00, 32'h0BADF00D, 32'd9, 4'd12, 32'h0BADF00D * 32'd9, acc, ok);
        void'(q.pop_back());
        step(); step(); step(); step();
        rst_in = 1'b1;
        rdy_in = 1'b0;
        step();
        n_cmp++;
        if ({in_ready, out_valid, out_result, out_tag} !== {1'b1, 1'b0, 32'd0, 4'd0}) begin
            n_err++;
            $display("FAIL reset_midop: got rdy=%b vld=%b res=%h tag=%h, want 1 0 0 0",
                     in_ready, out_valid, out_result, out_tag);
        end
        rst_in = 1'b0;
        rdy_in = 1'b1;
        step();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, want completion");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_basic();
        test_arith();
        test_backpressure();
        test_flush();
        test_stall();
        test_back_to_back();
        test_reset_midop();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
